id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 16-bit, 4-bit-opcode pipelined CPU, directly downstream of the opcode control decoder.
- Registers decoded control and operands into EX.
- Detects load-use hazards: stalls the front end and inserts a bubble.
- Kills the ID instruction on flush.
- Runs the halt drain sequence once HLT reaches EX.

---
 rtl/wisc_pkg.sv | 42 ++++
 rtl/id_ex_stage_hazard_detect.sv | 28 ++
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit, 4-bit-opcode pipelined CPU.
// Holds opcode, branch, alu_src and lb encodings plus the halt FSM state type.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_B    = 3'b001;
    localparam logic [2:0] BR_BR   = 3'b010;
    localparam logic [2:0] BR_PCS  = 3'b011;
    localparam logic [2:0] BR_HLT  = 3'b100;

    localparam logic [1:0] ALU_SRC_RT    = 2'b00;
    localparam logic [1:0] ALU_SRC_IMM   = 2'b01;
    localparam logic [1:0] ALU_SRC_SHAMT = 2'b10;

    localparam logic [1:0] LB_NONE = 2'b00;
    localparam logic [1:0] LB_LLB  = 2'b01;
    localparam logic [1:0] LB_LHB  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination is read by ID.
// Ports: ex_valid/ex_memtoreg/ex_rd from EX, id_valid/id_rs/id_rt/*_used from ID; hazard out.
module hazard_detect
    import wisc_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic              ex_valid,
    input  logic              ex_memtoreg,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    output logic              hazard
);

    logic ex_load;
    logic src_match;

    // r0 is hardwired zero, so a load to r0 never creates a dependency
    assign ex_load   = ex_valid & ex_memtoreg & (ex_rd != '0);
    assign src_match = (id_rs_used & (id_rs == ex_rd))
                     | (id_rt_used & (id_rt == ex_rd));
    assign hazard    = ex_load & id_valid & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble and halt drain FSM.
// Ports: id_* decoded instruction in, flush in; ex_* registered copies, stall (comb), halted (reg).
module id_ex_stage
    import wisc_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int REG_AW       = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic              id_rf_write,
    input  logic              id_dm_write,
    input  logic              id_memtoreg,
    input  logic [1:0]        id_lb,
    input  logic [1:0]        id_alu_src,
    input  logic [2:0]        id_branch,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc_next,
    input  logic              flush,
    output logic              ex_valid,
    output logic [3:0]        ex_opcode,
    output logic              ex_rf_write,
    output logic              ex_dm_write,
    output logic              ex_memtoreg,
    output logic [1:0]        ex_lb,
    output logic [1:0]        ex_alu_src,
    output logic [2:0]        ex_branch,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc_next,
    output logic              stall,
    output logic              halted
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    halt_state_t      state;
    halt_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             hazard;
    logic             cap;
    logic             hlt_cap;

    hazard_detect #(
        .REG_AW(REG_AW)
    ) u_hazard (
        .ex_valid   (ex_valid),
        .ex_memtoreg(ex_memtoreg),
        .ex_rd      (ex_rd),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .hazard     (hazard)
    );

    // Anything that is not a real capture becomes an all-zero bubble
    assign cap     = (state == ST_RUN) & ~flush & ~hazard & id_valid;
    assign hlt_cap = cap & (id_branch == BR_HLT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_rf_write <= 1'b0;
            ex_dm_write <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_lb       <= '0;
            ex_alu_src  <= '0;
            ex_branch   <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_pc_next  <= '0;
        end else if (cap) begin
            ex_valid    <= 1'b1;
            ex_opcode   <= id_opcode;
            ex_rf_write <= id_rf_write;
            ex_dm_write <= id_dm_write;
            ex_memtoreg <= id_memtoreg;
            ex_lb       <= id_lb;
            ex_alu_src  <= id_alu_src;
            ex_branch   <= id_branch;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_rdata1   <= id_rdata1;
            ex_rdata2   <= id_rdata2;
            ex_imm      <= id_imm;
            ex_pc_next  <= id_pc_next;
        end else begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_rf_write <= 1'b0;
            ex_dm_write <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_lb       <= '0;
            ex_alu_src  <= '0;
            ex_branch   <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_pc_next  <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            cnt    <= '0;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            halted <= (state_next == ST_HALTED);
        end
    end

    // Counter stops at CNT_LAST because the FSM leaves DRAIN there
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_RUN: begin
                if (hlt_cap) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt == CNT_LAST) begin
                    state_next = ST_HALTED;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        stall = (hazard & ~flush) | (state != ST_RUN);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage.
// Covers capture, load-use stall, flush priority, r0/unused-source cases, reset and halt drain.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic        id_rf_write;
    logic        id_dm_write;
    logic        id_memtoreg;
    logic [1:0]  id_lb;
    logic [1:0]  id_alu_src;
    logic [2:0]  id_branch;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic [3:0]  id_rd;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [15:0] id_rdata1;
    logic [15:0] id_rdata2;
    logic [15:0] id_imm;
    logic [15:0] id_pc_next;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic        ex_rf_write;
    logic        ex_dm_write;
    logic        ex_memtoreg;
    logic [1:0]  ex_lb;
    logic [1:0]  ex_alu_src;
    logic [2:0]  ex_branch;
    logic [3:0]  ex_rs;
    logic [3:0]  ex_rt;
    logic [3:0]  ex_rd;
    logic [15:0] ex_rdata1;
    logic [15:0] ex_rdata2;
    logic [15:0] ex_imm;
    logic [15:0] ex_pc_next;
    logic        stall;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [3:0]  opcode;
        logic        rf_write;
        logic        dm_write;
        logic        memtoreg;
        logic [1:0]  lb;
        logic [1:0]  alu_src;
        logic [2:0]  branch;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic        rs_used;
        logic        rt_used;
        logic [15:0] rdata1;
        logic [15:0] rdata2;
        logic [15:0] imm;
        logic [15:0] pc_next;
        logic        flush;
        logic        exp_stall;
        logic        exp_cap;
    } vec_t;

    vec_t vecs[16];

    id_ex_stage #(
        .DATA_W(16),
        .REG_AW(4),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(id_valid),
        .id_opcode(id_opcode),
        .id_rf_write(id_rf_write),
        .id_dm_write(id_dm_write),
        .id_memtoreg(id_memtoreg),
        .id_lb(id_lb),
        .id_alu_src(id_alu_src),
        .id_branch(id_branch),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_rd(id_rd),
        .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used),
        .id_rdata1(id_rdata1),
        .id_rdata2(id_rdata2),
        .id_imm(id_imm),
        .id_pc_next(id_pc_next),
        .flush(flush),
        .ex_valid(ex_valid),
        .ex_opcode(ex_opcode),
        .ex_rf_write(ex_rf_write),
        .ex_dm_write(ex_dm_write),
        .ex_memtoreg(ex_memtoreg),
        .ex_lb(ex_lb),
        .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch),
        .ex_rs(ex_rs),
        .ex_rt(ex_rt),
        .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1),
        .ex_rdata2(ex_rdata2),
        .ex_imm(ex_imm),
        .ex_pc_next(ex_pc_next),
        .stall(stall),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act,
                         input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [89:0] act_bundle();
        return {ex_opcode, ex_rf_write, ex_dm_write, ex_memtoreg, ex_lb,
                ex_alu_src, ex_branch, ex_rs, ex_rt, ex_rd,
                ex_rdata1, ex_rdata2, ex_imm, ex_pc_next};
    endfunction

    function automatic logic [89:0] exp_bundle(input vec_t v);
        if (!v.exp_cap) return '0;
        return {v.opcode, v.rf_write, v.dm_write, v.memtoreg, v.lb,
                v.alu_src, v.branch, v.rs, v.rt, v.rd,
                v.rdata1, v.rdata2, v.imm, v.pc_next};
    endfunction

    task automatic drive(input vec_t v);
        id_valid    = v.valid;
        id_opcode   = v.opcode;
        id_rf_write = v.rf_write;
        id_dm_write = v.dm_write;
        id_memtoreg = v.memtoreg;
        id_lb       = v.lb;
        id_alu_src  = v.alu_src;
        id_branch   = v.branch;
        id_rs       = v.rs;
        id_rt       = v.rt;
        id_rd       = v.rd;
        id_rs_used  = v.rs_used;
        id_rt_used  = v.rt_used;
        id_rdata1   = v.rdata1;
        id_rdata2   = v.rdata2;
        id_imm      = v.imm;
        id_pc_next  = v.pc_next;
        flush       = v.flush;
    endtask

    initial begin
        vec_t hv;
        vec_t lw5;
        vec_t sub5;
        string tag;

        // valid op rfw dmw m2r lb as br rs rt rd rsu rtu rd1 rd2 imm pc flush stall cap
        vecs[0]  = '{1, 4'h0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 4'd1, 4'd2, 4'd3,
                     1, 1, 16'h0005, 16'h0007, 16'h0000, 16'h0002, 0, 0, 1};
        vecs[1]  = '{1, 4'h8, 1, 0, 1, 2'b00, 2'b01, 3'b000, 4'd1, 4'd0, 4'd5,
                     1, 0, 16'h0100, 16'h0000, 16'h0004, 16'h0004, 0, 0, 1};
        vecs[2]  = '{1, 4'h1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 4'd5, 4'd2, 4'd6,
                     1, 1, 16'h0033, 16'h0011, 16'h0000, 16'h0006, 0, 1, 0};
        vecs[3]  = '{1, 4'h1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 4'd5, 4'd2, 4'd6,
                     1, 1, 16'h0033, 16'h0011, 16'h0000, 16'h0006, 0, 0, 1};
        vecs[4]  = '{1, 4'h8, 1, 0, 1, 2'b00, 2'b01, 3'b000, 4'd1, 4'd0, 4'd0,
                     1, 0, 16'h0200, 16'h0000, 16'h0008, 16'h0008, 0, 0, 1};
        vecs[5]  = '{1, 4'h0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 4'd0, 4'd0, 4'd4,
                     1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h000A, 0, 0, 1};
        vecs[6]  = '{1, 4'h8, 1, 0, 1, 2'b00, 2'b01, 3'b000, 4'd1, 4'd0, 4'd5,
                     1, 0, 16'h0300, 16'h0000, 16'h0002, 16'h000C, 0, 0, 1};
        vecs[7]  = '{1, 4'hA, 1, 0, 0, 2'b01, 2'b01, 3'b000, 4'd7, 4'd5, 4'd7,
                     1, 0, 16'h0044, 16'h0055, 16'h0012, 16'h000E, 0, 0, 1};
        vecs[8]  = '{1, 4'h8, 1, 0, 1, 2'b00, 2'b01, 3'b000, 4'd1, 4'd0, 4'd5,
                     1, 0, 16'h0300, 16'h0000, 16'h0002, 16'h0010, 0, 0, 1};
        vecs[9]  = '{1, 4'h1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 4'd5, 4'd2, 4'd6,
                     1, 1, 16'h0001, 16'h0002, 16'h0000, 16'h0012, 1, 0, 0};
        vecs[10] = '{0, 4'h2, 1, 1, 1, 2'b11, 2'b10, 3'b100, 4'd5, 4'd5, 4'd5,
                     1, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0};
        vecs[11] = '{1, 4'h9, 0, 1, 0, 2'b00, 2'b01, 3'b000, 4'd1, 4'd8, 4'd8,
                     1, 1, 16'h0400, 16'hBEEF, 16'h0006, 16'h0016, 0, 0, 1};
        vecs[12] = '{1, 4'h0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 4'd8, 4'd8, 4'd9,
                     1, 1, 16'h0001, 16'h0002, 16'h0000, 16'h0018, 0, 0, 1};
        vecs[13] = '{1, 4'h8, 1, 0, 1, 2'b00, 2'b01, 3'b000, 4'd2, 4'd0, 4'd9,
                     1, 0, 16'h0010, 16'h0000, 16'h0000, 16'h001A, 0, 0, 1};
        vecs[14] = '{1, 4'h0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 4'd1, 4'd9, 4'd10,
                     1, 1, 16'h0003, 16'h0004, 16'h0000, 16'h001C, 0, 1, 0};
        vecs[15] = '{1, 4'h0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 4'd1, 4'd9, 4'd10,
                     1, 1, 16'h0003, 16'h0004, 16'h0000, 16'h001C, 0, 0, 1};

        rst = 1'b1;
        drive(vecs[0]);
        #2;
        check("reset_ex_valid", 96'(ex_valid), 96'(0));
        check("reset_bundle", 96'(act_bundle()), 96'(0));
        check("reset_stall", 96'(stall), 96'(0));
        check("reset_halted", 96'(halted), 96'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            tag = $sformatf("v%0d_stall", i);
            check(tag, 96'(stall), 96'(vecs[i].exp_stall));
            @(posedge clk);
            #1;
            tag = $sformatf("v%0d_ex_valid", i);
            check(tag, 96'(ex_valid), 96'(vecs[i].exp_cap));
            tag = $sformatf("v%0d_bundle", i);
            check(tag, 96'(act_bundle()), 96'(exp_bundle(vecs[i])));
        end

        // Async reset asserted mid-cycle while a hazard is pending
        lw5  = vecs[1];
        sub5 = vecs[2];
        @(negedge clk);
        drive(lw5);
        @(negedge clk);
        drive(sub5);
        #2;
        check("midrst_pre_stall", 96'(stall), 96'(1));
        rst = 1'b1;
        #1;
        check("midrst_ex_valid", 96'(ex_valid), 96'(0));
        check("midrst_bundle", 96'(act_bundle()), 96'(0));
        check("midrst_stall", 96'(stall), 96'(0));
        check("midrst_halted", 96'(halted), 96'(0));
        @(negedge clk);
        rst = 1'b0;

        // Halt drain: hlt captured at E0, halted after E3
        hv = '{1, 4'hF, 0, 0, 0, 2'b00, 2'b00, 3'b100, 4'd0, 4'd0, 4'd0,
               0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 0, 0, 1};
        @(negedge clk);
        drive(hv);
        @(posedge clk);
        #1;
        check("hlt_e0_ex_valid", 96'(ex_valid), 96'(1));
        check("hlt_e0_branch", 96'(ex_branch), 96'(3'b100));
        check("hlt_e0_stall", 96'(stall), 96'(1));
        check("hlt_e0_halted", 96'(halted), 96'(0));
        @(negedge clk);
        drive(vecs[0]);
        flush = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            tag = $sformatf("hlt_e%0d_halted", e);
            check(tag, 96'(halted), 96'(e >= 3));
            tag = $sformatf("hlt_e%0d_stall", e);
            check(tag, 96'(stall), 96'(1));
            tag = $sformatf("hlt_e%0d_ex_valid", e);
            check(tag, 96'(ex_valid), 96'(0));
            @(negedge clk);
            flush = (e % 2 == 0);
        end

        rst = 1'b1;
        #1;
        check("hlt_rst_halted", 96'(halted), 96'(0));
        check("hlt_rst_stall", 96'(stall), 96'(0));
        @(negedge clk);
        rst = 1'b0;
        drive(vecs[0]);
        @(posedge clk);
        #1;
        check("post_hlt_capture", 96'(ex_valid), 96'(1));
        check("post_hlt_bundle", 96'(act_bundle()), 96'(exp_bundle(vecs[0])));
        check("post_hlt_halted", 96'(halted), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
